// File: rtl/peak_tracker_if.sv
// rtl/peak_tracker_if.sv - sample/axis inputs and peak result outputs of peak_tracker
interface peak_tracker_if #(
    parameter int DATA_W   = 12,
    parameter int POS_W    = 32,
    parameter int NUM_AXES = 2,
    parameter int CNT_W    = 16
);
    localparam int AXIS_W = (NUM_AXES > 1) ? $clog2(NUM_AXES) : 1;

    logic                      START;
    logic                      STOP;
    logic                      S_VALID;
    logic [DATA_W-1:0]         S_DATA;
    logic [NUM_AXES-1:0]       AXIS_EN;
    logic [NUM_AXES*POS_W-1:0] POS;
    logic [DATA_W-1:0]         MAX_VAL;
    logic [POS_W-1:0]          MAX_POS;
    logic [AXIS_W-1:0]         MAX_AXIS;
    logic                      UPDATE;
    logic                      BUSY;
    logic                      DONE;
    logic [CNT_W-1:0]          SAMPLE_CNT;

    modport master (
        output START, STOP, S_VALID, S_DATA, AXIS_EN, POS,
        input  MAX_VAL, MAX_POS, MAX_AXIS, UPDATE, BUSY, DONE, SAMPLE_CNT
    );

    modport slave (
        input  START, STOP, S_VALID, S_DATA, AXIS_EN, POS,
        output MAX_VAL, MAX_POS, MAX_AXIS, UPDATE, BUSY, DONE, SAMPLE_CNT
    );
endinterface

// File: rtl/peak_tracker.sv
// rtl/peak_tracker.sv - peak ADC sample tracker with hysteresis and axis position capture
module peak_tracker #(
    parameter int DATA_W   = 12,
    parameter int POS_W    = 32,
    parameter int NUM_AXES = 2,
    parameter int HYST     = 0,
    parameter int CNT_W    = 16
) (
    input  logic          CLK,
    input  logic          RST,
    peak_tracker_if.slave bus
);
    localparam int AXIS_W = (NUM_AXES > 1) ? $clog2(NUM_AXES) : 1;

    typedef enum logic [1:0] {IDLE, TRACK, FIN} state_t;

    state_t            state;
    logic              first;
    logic [DATA_W-1:0] max_val;
    logic [POS_W-1:0]  max_pos;
    logic [AXIS_W-1:0] max_axis;
    logic              update;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  sample_cnt;

    logic              sel_found;
    logic [AXIS_W-1:0] sel_idx;
    logic [POS_W-1:0]  sel_pos;
    logic [DATA_W:0]   thresh;
    logic              capture;

    // Scan from the top down so the lowest enabled axis is the one left standing.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_pos   = '0;
        for (int i = NUM_AXES - 1; i >= 0; i--) begin
            if (bus.AXIS_EN[i]) begin
                sel_found = 1'b1;
                sel_idx   = AXIS_W'(i);
                sel_pos   = bus.POS[i*POS_W +: POS_W];
            end
        end
    end

    // One extra bit keeps max+HYST from wrapping, which freezes capture near full scale.
    always_comb begin
        thresh  = {1'b0, max_val} + (DATA_W + 1)'(HYST);
        capture = sel_found && (first || ({1'b0, bus.S_DATA} > thresh));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            first      <= 1'b1;
            max_val    <= '0;
            max_pos    <= '0;
            max_axis   <= '0;
            update     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sample_cnt <= '0;
        end else begin
            update <= 1'b0;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.START) begin
                        state      <= TRACK;
                        busy       <= 1'b1;
                        first      <= 1'b1;
                        max_val    <= '0;
                        max_pos    <= '0;
                        max_axis   <= '0;
                        sample_cnt <= '0;
                    end
                end
                TRACK: begin
                    if (bus.START) begin
                        first      <= 1'b1;
                        max_val    <= '0;
                        max_pos    <= '0;
                        max_axis   <= '0;
                        sample_cnt <= '0;
                    end else begin
                        if (bus.S_VALID) begin
                            if (sample_cnt != '1) begin
                                sample_cnt <= sample_cnt + CNT_W'(1);
                            end
                            if (capture) begin
                                max_val  <= bus.S_DATA;
                                max_pos  <= sel_pos;
                                max_axis <= sel_idx;
                                update   <= 1'b1;
                                first    <= 1'b0;
                            end
                        end
                        if (bus.STOP) begin
                            state <= FIN;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.MAX_VAL    = max_val;
    assign bus.MAX_POS    = max_pos;
    assign bus.MAX_AXIS   = max_axis;
    assign bus.UPDATE     = update;
    assign bus.BUSY       = busy;
    assign bus.DONE       = done;
    assign bus.SAMPLE_CNT = sample_cnt;
endmodule

// File: tb/tb_peak_tracker.sv
// tb/tb_peak_tracker.sv - scoreboard bench for peak_tracker across three parameter sets
module tb_peak_tracker;
    logic        CLK = 1'b0;
    logic        rst0, rst1, rst2;
    logic        start, stop, s_valid;
    logic [11:0] s_data;
    logic [1:0]  axis_en;
    logic [63:0] pos;
    int          dsel;

    always #5 CLK = ~CLK;

    peak_tracker_if #(.DATA_W(12), .POS_W(32), .NUM_AXES(2), .CNT_W(16)) if0 ();
    peak_tracker_if #(.DATA_W(12), .POS_W(32), .NUM_AXES(2), .CNT_W(16)) if1 ();
    peak_tracker_if #(.DATA_W(12), .POS_W(32), .NUM_AXES(2), .CNT_W(2))  if2 ();

    assign if0.START = start, if0.STOP = stop, if0.S_VALID = s_valid,
           if0.S_DATA = s_data, if0.AXIS_EN = axis_en, if0.POS = pos;
    assign if1.START = start, if1.STOP = stop, if1.S_VALID = s_valid,
           if1.S_DATA = s_data, if1.AXIS_EN = axis_en, if1.POS = pos;
    assign if2.START = start, if2.STOP = stop, if2.S_VALID = s_valid,
           if2.S_DATA = s_data, if2.AXIS_EN = axis_en, if2.POS = pos;

    peak_tracker #(.DATA_W(12), .POS_W(32), .NUM_AXES(2), .HYST(0), .CNT_W(16))
        dut0 (.CLK(CLK), .RST(rst0), .bus(if0));
    peak_tracker #(.DATA_W(12), .POS_W(32), .NUM_AXES(2), .HYST(8), .CNT_W(16))
        dut1 (.CLK(CLK), .RST(rst1), .bus(if1));
    peak_tracker #(.DATA_W(12), .POS_W(32), .NUM_AXES(2), .HYST(2), .CNT_W(2))
        dut2 (.CLK(CLK), .RST(rst2), .bus(if2));

    logic [11:0] o_val;
    logic [31:0] o_pos;
    logic        o_axis, o_upd, o_busy, o_done;
    logic [15:0] o_cnt;

    always_comb begin
        o_val = '0; o_pos = '0; o_axis = 1'b0; o_upd = 1'b0;
        o_busy = 1'b0; o_done = 1'b0; o_cnt = '0;
        case (dsel)
            0: begin
                o_val = if0.MAX_VAL; o_pos = if0.MAX_POS; o_axis = if0.MAX_AXIS;
                o_upd = if0.UPDATE; o_busy = if0.BUSY; o_done = if0.DONE; o_cnt = if0.SAMPLE_CNT;
            end
            1: begin
                o_val = if1.MAX_VAL; o_pos = if1.MAX_POS; o_axis = if1.MAX_AXIS;
                o_upd = if1.UPDATE; o_busy = if1.BUSY; o_done = if1.DONE; o_cnt = if1.SAMPLE_CNT;
            end
            default: begin
                o_val = if2.MAX_VAL; o_pos = if2.MAX_POS; o_axis = if2.MAX_AXIS;
                o_upd = if2.UPDATE; o_busy = if2.BUSY; o_done = if2.DONE; o_cnt = 16'(if2.SAMPLE_CNT);
            end
        endcase
    end

    typedef struct {
        logic [11:0] val;
        logic [31:0] pos;
        logic        axis;
    } cap_t;

    cap_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   upd_cnt  = 0;
    int   done_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (o_done) done_cnt++;
        if (o_upd) begin
            upd_cnt++;
            if (exp_q.size() == 0) begin
                check_eq("unexpected_update", 32'd1, 32'd0);
            end else begin
                cap_t e;
                e = exp_q.pop_front();
                check_eq("cap_val", 32'(o_val), 32'(e.val));
                check_eq("cap_pos", o_pos, e.pos);
                check_eq("cap_axis", 32'(o_axis), 32'(e.axis));
            end
        end
    end

    task automatic drive(input bit st, input bit sp, input bit sv, input logic [11:0] d,
                         input logic [1:0] en, input logic [31:0] p0, input logic [31:0] p1,
                         input bit cap);
        cap_t e;
        start = st; stop = sp; s_valid = sv; s_data = d; axis_en = en; pos = {p1, p0};
        if (cap) begin
            e.val  = d;
            e.pos  = en[0] ? p0 : p1;
            e.axis = en[0] ? 1'b0 : 1'b1;
            exp_q.push_back(e);
        end
        @(negedge CLK);
    endtask

    task automatic idle(input int n);
        start = 0; stop = 0; s_valid = 0; s_data = '0; axis_en = '0; pos = '0;
        repeat (n) @(negedge CLK);
    endtask

    task automatic do_reset(input int which);
        start = 0; stop = 0; s_valid = 0;
        rst0 = 1; rst1 = 1; rst2 = 1; dsel = which;
        repeat (2) @(negedge CLK);
        rst0 = (which != 0); rst1 = (which != 1); rst2 = (which != 2);
        exp_q.delete(); upd_cnt = 0; done_cnt = 0;
    endtask

    task automatic end_sweep(input string tag, input int exp_upd);
        check_eq({tag, "_done_pulse"}, 32'(o_done), 32'd1);
        idle(1);
        check_eq({tag, "_done_cleared"}, 32'(o_done), 32'd0);
        check_eq({tag, "_busy_after"}, 32'(o_busy), 32'd0);
        check_eq({tag, "_done_count"}, done_cnt, 1);
        check_eq({tag, "_upd_count"}, upd_cnt, exp_upd);
        check_eq({tag, "_sb_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        s_data = '0; axis_en = '0; pos = '0;
        do_reset(0);
        // Reset state
        check_eq("rst_val", 32'(o_val), 0);
        check_eq("rst_pos", o_pos, 0);
        check_eq("rst_axis", 32'(o_axis), 0);
        check_eq("rst_cnt", 32'(o_cnt), 0);
        check_eq("rst_busy", 32'(o_busy), 0);
        check_eq("rst_done", 32'(o_done), 0);

        // Basic peak
        drive(1, 0, 0, 0, 2'b01, 0, 0, 0);
        check_eq("t1_busy", 32'(o_busy), 1);
        drive(0, 0, 1, 100, 2'b01, 1000, 0, 1);
        drive(0, 0, 1, 300, 2'b01, 1100, 0, 1);
        drive(0, 0, 1, 200, 2'b01, 1200, 0, 0);
        drive(0, 1, 0, 0, 2'b01, 0, 0, 0);
        end_sweep("t1", 2);
        check_eq("t1_val", 32'(o_val), 300);
        check_eq("t1_pos", o_pos, 1100);
        check_eq("t1_axis", 32'(o_axis), 0);
        check_eq("t1_cnt", 32'(o_cnt), 3);
        idle(2);
        check_eq("t1_hold_val", 32'(o_val), 300);

        // Hysteresis and equality, HYST=8 on axis 1
        do_reset(1);
        drive(1, 0, 0, 0, 2'b00, 0, 0, 0);
        drive(0, 0, 1, 500, 2'b10, 0, 2000, 1);
        drive(0, 0, 1, 505, 2'b10, 0, 2001, 0);
        drive(0, 0, 1, 508, 2'b10, 0, 2002, 0);
        drive(0, 0, 1, 509, 2'b10, 0, 2003, 1);
        drive(0, 0, 1, 509, 2'b10, 0, 2004, 0);
        drive(0, 1, 0, 0, 2'b00, 0, 0, 0);
        end_sweep("t2", 2);
        check_eq("t2_val", 32'(o_val), 509);
        check_eq("t2_pos", o_pos, 2003);
        check_eq("t2_axis", 32'(o_axis), 1);
        check_eq("t2_cnt", 32'(o_cnt), 5);

        // Axis priority and no axis
        do_reset(0);
        drive(1, 0, 0, 0, 2'b00, 0, 0, 0);
        drive(0, 0, 1, 700, 2'b11, 3000, 3100, 1);
        drive(0, 0, 1, 900, 2'b00, 3200, 3300, 0);
        check_eq("t3_cnt", 32'(o_cnt), 2);
        check_eq("t3_val", 32'(o_val), 700);
        check_eq("t3_pos", o_pos, 3000);
        drive(0, 1, 0, 0, 2'b00, 0, 0, 0);
        end_sweep("t3", 1);

        // Restart with simultaneous START/STOP, then STOP with a sample
        do_reset(0);
        drive(1, 0, 0, 0, 2'b00, 0, 0, 0);
        drive(0, 0, 1, 400, 2'b01, 4000, 0, 1);
        drive(0, 0, 1, 100, 2'b01, 4001, 0, 0);
        drive(1, 1, 1, 999, 2'b01, 9999, 0, 0);
        check_eq("t4_busy", 32'(o_busy), 1);
        check_eq("t4_val", 32'(o_val), 0);
        check_eq("t4_pos", o_pos, 0);
        check_eq("t4_cnt", 32'(o_cnt), 0);
        check_eq("t4_no_done", 32'(o_done), 0);
        drive(0, 1, 1, 50, 2'b01, 50, 0, 1);
        end_sweep("t4", 2);
        check_eq("t4_val_end", 32'(o_val), 50);
        check_eq("t4_cnt_end", 32'(o_cnt), 1);

        // Reset mid-sweep
        do_reset(0);
        drive(1, 0, 0, 0, 2'b00, 0, 0, 0);
        drive(0, 0, 1, 600, 2'b01, 6000, 0, 1);
        drive(0, 0, 1, 800, 2'b10, 0, 6100, 1);
        idle(0);
        rst0 = 1;
        @(negedge CLK);
        rst0 = 0;
        check_eq("t5_val", 32'(o_val), 0);
        check_eq("t5_pos", o_pos, 0);
        check_eq("t5_axis", 32'(o_axis), 0);
        check_eq("t5_cnt", 32'(o_cnt), 0);
        check_eq("t5_busy", 32'(o_busy), 0);
        check_eq("t5_done", 32'(o_done), 0);
        drive(0, 0, 1, 900, 2'b01, 7000, 0, 0);
        drive(0, 0, 1, 950, 2'b01, 7001, 0, 0);
        drive(0, 1, 0, 0, 2'b00, 0, 0, 0);
        idle(2);
        check_eq("t5_idle_cnt", 32'(o_cnt), 0);
        check_eq("t5_idle_val", 32'(o_val), 0);
        check_eq("t5_idle_busy", 32'(o_busy), 0);
        check_eq("t5_done_count", done_cnt, 0);
        check_eq("t5_upd_count", upd_cnt, 2);

        // Near full scale with HYST=2, and 2-bit counter saturation
        do_reset(2);
        drive(1, 0, 0, 0, 2'b00, 0, 0, 0);
        drive(0, 0, 1, 4094, 2'b01, 8000, 0, 1);
        drive(0, 0, 1, 4095, 2'b01, 8001, 0, 0);
        drive(0, 0, 1, 4095, 2'b01, 8002, 0, 0);
        check_eq("t6_cnt3", 32'(o_cnt), 3);
        drive(0, 0, 1, 10, 2'b01, 8003, 0, 0);
        drive(0, 0, 1, 4095, 2'b01, 8004, 0, 0);
        check_eq("t6_cnt_sat", 32'(o_cnt), 3);
        drive(0, 1, 0, 0, 2'b00, 0, 0, 0);
        end_sweep("t6", 1);
        check_eq("t6_val", 32'(o_val), 4094);
        check_eq("t6_pos", o_pos, 8000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
